// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and datapath widths used by the
// command driver, its response FIFO and the combinational alu.
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND  = 3'b010;
    localparam logic [OP_W-1:0] OP_OR   = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b111;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command and response channels between a command source (master) and the
// alu command driver (slave).
interface alu_cmd_driver_if #(
    parameter int TAG_W = 4
);
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [OPND_W-1:0] cmd_a;
    logic [OPND_W-1:0] cmd_b;
    logic [TAG_W-1:0]  cmd_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_result;
    logic [TAG_W-1:0]  rsp_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_tag
    );

endinterface

// File: rtl/alu.sv
// Combinational 4-bit ALU producing an 8-bit result. Operands are
// zero-extended before every operation, so SUB/NOT/XNOR wrap in 8 bits.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   opcode,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  result
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    // Select the operation on the zero-extended operands.
    always_comb begin
        a_ext  = {{(RES_W-OPND_W){1'b0}}, a};
        b_ext  = {{(RES_W-OPND_W){1'b0}}, b};
        result = '0;
        case (opcode)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_AND:  result = a_ext & b_ext;
            OP_OR:   result = a_ext | b_ext;
            OP_XOR:  result = a_ext ^ b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_NOT:  result = ~a_ext;
            OP_XNOR: result = ~(a_ext ^ b_ext);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rsp_fifo.sv
// Response FIFO: DEPTH entries of {result, tag}, synchronous reset,
// simultaneous push and pop allowed even when full.
module alu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards all buffered entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Drives the alu from a tagged command channel: one stage register feeds the
// alu, its result is captured a cycle later into the response FIFO, and
// responses return in command order.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmd_driver_if.slave   bus,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_result,
    output logic [CNT_W-1:0]  ops_issued
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              s_valid_q, s_valid_d;
    logic [OP_W-1:0]   s_opcode_q, s_opcode_d;
    logic [OPND_W-1:0] s_a_q, s_a_d;
    logic [OPND_W-1:0] s_b_q, s_b_d;
    logic [TAG_W-1:0]  s_tag_q, s_tag_d;
    logic [CNT_W-1:0]  ops_q, ops_d;

    logic              accept;
    logic [CW:0]       occupancy;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [RES_W+TAG_W-1:0] fifo_head;

    assign alu_opcode = s_opcode_q;
    assign alu_a      = s_a_q;
    assign alu_b      = s_b_q;
    assign ops_issued = ops_q;

    // Ready counts the stage entry as already occupying a FIFO slot, so a
    // full FIFO alone is not enough to gate commands.
    always_comb begin
        occupancy     = {1'b0, fifo_count} + {{CW{1'b0}}, s_valid_q};
        bus.cmd_ready = ~rst & ~fifo_full & (occupancy < (CW+1)'(DEPTH));
        accept        = bus.cmd_valid & bus.cmd_ready;
    end

    // Stage reload on accept; alu inputs hold their last value when idle.
    always_comb begin
        s_valid_d  = accept;
        s_opcode_d = s_opcode_q;
        s_a_d      = s_a_q;
        s_b_d      = s_b_q;
        s_tag_d    = s_tag_q;
        ops_d      = ops_q;
        if (accept) begin
            s_opcode_d = bus.cmd_opcode;
            s_a_d      = bus.cmd_a;
            s_b_d      = bus.cmd_b;
            s_tag_d    = bus.cmd_tag;
            if (ops_q != '1) begin
                ops_d = ops_q + CNT_W'(1);
            end
        end
    end

    // Stage and counter registers; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid_q  <= 1'b0;
            s_opcode_q <= '0;
            s_a_q      <= '0;
            s_b_q      <= '0;
            s_tag_q    <= '0;
            ops_q      <= '0;
        end else begin
            s_valid_q  <= s_valid_d;
            s_opcode_q <= s_opcode_d;
            s_a_q      <= s_a_d;
            s_b_q      <= s_b_d;
            s_tag_q    <= s_tag_d;
            ops_q      <= ops_d;
        end
    end

    alu_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W + TAG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid_q),
        .push_data ({alu_result, s_tag_q}),
        .pop       (bus.rsp_valid & bus.rsp_ready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Head of FIFO presented on the response channel.
    always_comb begin
        bus.rsp_valid  = ~fifo_empty;
        bus.rsp_result = fifo_head[RES_W+TAG_W-1:TAG_W];
        bus.rsp_tag    = fifo_head[TAG_W-1:0];
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with the alu connected behind it.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic [2:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_result;
    logic [3:0] ops_issued;

    int checks = 0;
    int errors = 0;
    int accepted;

    alu_cmd_driver_if #(.TAG_W(4)) bus ();

    alu_cmd_driver #(
        .DEPTH (4),
        .TAG_W (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .ops_issued (ops_issued)
    );

    alu u_alu (
        .opcode (alu_opcode),
        .a      (alu_a),
        .b      (alu_b),
        .result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Present one command on the command channel.
    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] a,
                                 input logic [3:0] b, input logic [3:0] tag);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_tag    = tag;
    endtask

    task automatic idleCmd();
        bus.cmd_valid = 1'b0;
    endtask

    // Check the head response against an expected {result, tag}.
    task automatic checkRsp(input string name, input logic [7:0] res, input logic [3:0] tag);
        checkOutput({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        checkOutput({name, "_result"}, 32'(bus.rsp_result), 32'(res));
        checkOutput({name, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
    endtask

    // Hand-computed vectors for the streaming tests.
    logic [2:0] bb_op  [4] = '{OP_SUB, OP_NOT, OP_XNOR, OP_MUL};
    logic [3:0] bb_a   [4] = '{4'h3, 4'h5, 4'h3, 4'hF};
    logic [3:0] bb_b   [4] = '{4'h5, 4'h0, 4'h5, 4'hF};
    logic [7:0] bb_res [4] = '{8'hFE, 8'hFA, 8'hF9, 8'hE1};

    logic [2:0] bp_op  [6] = '{OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_MUL};
    logic [3:0] bp_a   [6] = '{4'hC, 4'hC, 4'hC, 4'hF, 4'h1, 4'h2};
    logic [3:0] bp_b   [6] = '{4'hA, 4'hA, 4'hA, 4'hF, 4'h1, 4'h2};
    logic [7:0] bp_res [4] = '{8'h08, 8'h0E, 8'h06, 8'h1E};

    logic [2:0] sp_op  [4] = '{OP_ADD, OP_SUB, OP_AND, OP_XOR};
    logic [3:0] sp_a   [4] = '{4'h1, 4'h0, 4'hF, 4'hF};
    logic [3:0] sp_b   [4] = '{4'h2, 4'h1, 4'h5, 4'h0};
    logic [7:0] sp_res [4] = '{8'h03, 8'hFF, 8'h05, 8'h0F};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_tag    = '0;
        bus.rsp_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_ops", 32'(ops_issued), 32'd0);
        checkOutput("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single add: response visible after the second edge
        bus.rsp_ready = 1'b1;
        applyStimulus(OP_ADD, 4'h9, 4'h8, 4'h3);
        @(negedge clk);
        idleCmd();
        checkOutput("add_alu_a", 32'(alu_a), 32'h9);
        checkOutput("add_alu_b", 32'(alu_b), 32'h8);
        checkOutput("add_early_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        checkRsp("add", 8'h11, 4'h3);
        @(negedge clk);
        checkOutput("add_popped", 32'(bus.rsp_valid), 32'd0);
        checkOutput("add_ops", 32'(ops_issued), 32'd1);
        checkOutput("add_hold_a", 32'(alu_a), 32'h9);

        // Back-to-back: one response per cycle, in order
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2) checkRsp("b2b", bb_res[c-2], 4'(c-2));
            if (c < 4) begin
                applyStimulus(bb_op[c], bb_a[c], bb_b[c], 4'(c));
                #1;
                checkOutput("b2b_ready", 32'(bus.cmd_ready), 32'd1);
            end else begin
                idleCmd();
            end
        end
        @(negedge clk);
        checkOutput("b2b_drained", 32'(bus.rsp_valid), 32'd0);
        checkOutput("b2b_ops", 32'(ops_issued), 32'd5);
        bus.rsp_ready = 1'b0;

        // Backpressure: only DEPTH commands get in
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (accepted < 6) applyStimulus(bp_op[accepted], bp_a[accepted], bp_b[accepted], 4'(accepted + 4));
            else idleCmd();
            #1;
            if (bus.cmd_ready) accepted++;
        end
        @(negedge clk);
        idleCmd();
        checkOutput("bp_accepted", 32'(accepted), 32'd4);
        checkOutput("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checkRsp("bp", bp_res[i], 4'(i + 4));
        end
        @(negedge clk);
        checkOutput("bp_drained", 32'(bus.rsp_valid), 32'd0);
        checkOutput("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
        checkOutput("bp_ops", 32'(ops_issued), 32'd9);
        bus.rsp_ready = 1'b0;

        // Simultaneous push and pop with count=3 and stage full
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus(sp_op[c], sp_a[c], sp_b[c], 4'(c + 8));
            #1;
            checkOutput("sp_ready", 32'(bus.cmd_ready), 32'd1);
        end
        @(negedge clk);
        idleCmd();
        checkOutput("sp_full_ready", 32'(bus.cmd_ready), 32'd0);
        checkRsp("sp", sp_res[0], 4'h8);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("sp_count_stable", 32'(bus.cmd_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            if (i > 1) @(negedge clk);
            checkRsp("sp", sp_res[i], 4'(i + 8));
        end
        @(negedge clk);
        checkOutput("sp_drained", 32'(bus.rsp_valid), 32'd0);
        checkOutput("sp_ops", 32'(ops_issued), 32'hD);
        bus.rsp_ready = 1'b0;

        // Reset with two buffered responses and one in the stage
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus(OP_OR, 4'(c), 4'h1, 4'(c));
        end
        @(negedge clk);
        idleCmd();
        checkOutput("mr_pre_valid", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mr_ops", 32'(ops_issued), 32'd0);
        checkOutput("mr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("mr_alu_a", 32'(alu_a), 32'd0);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("mr_no_stale1", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mr_ready_back", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        checkOutput("mr_no_stale2", 32'(bus.rsp_valid), 32'd0);
        applyStimulus(OP_ADD, 4'h2, 4'h3, 4'hC);
        @(negedge clk);
        idleCmd();
        @(negedge clk);
        checkRsp("mr_new", 8'h05, 4'hC);
        @(negedge clk);
        checkOutput("mr_new_popped", 32'(bus.rsp_valid), 32'd0);
        checkOutput("mr_new_ops", 32'(ops_issued), 32'd1);

        // Counter saturation at 4'hF
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(OP_ADD, 4'(i), 4'h1, 4'(i));
        end
        @(negedge clk);
        idleCmd();
        checkOutput("sat_below", 32'(ops_issued), 32'hE);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            applyStimulus(OP_ADD, 4'(i), 4'h2, 4'(i));
        end
        @(negedge clk);
        idleCmd();
        checkOutput("sat_top", 32'(ops_issued), 32'hF);
        repeat (3) @(negedge clk);
        checkOutput("sat_drained", 32'(bus.rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
